// File: rtl/tune_sequencer.sv
// -----------------------------------------------------------------------------
// tune_sequencer
// Walks a tune table of {pitch[7:4], dur[3:0]} entries and drives a tone
// generator. Each note sounds for dur*BEAT_COUNT clocks and is followed by
// GAP_CYCLES silent clocks. An entry with dur==0 ends the tune, or restarts
// it at address 0 when loop is set.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset, overrides every other input
//   start       : play request, honoured only while idle
//   stop        : abort request, wins over start, returns to idle next cycle
//   loop        : restart at address 0 on an end marker (sampled in FETCH)
//   rom_data    : tune entry at rom_addr (combinational ROM)
//   rom_addr    : tune table address
//   note_pitch  : pitch index for the tone generator, 0 = rest
//   tone_en     : tone generator enable
//   note_strobe : one-cycle pulse in the first cycle of each note
//   busy        : high whenever the sequencer is not idle
//   done        : one-cycle pulse when the tune ends normally
// -----------------------------------------------------------------------------
module tune_sequencer #(
    parameter int BEAT_COUNT = 100,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [7:0] rom_data,
    output logic [5:0] rom_addr,
    output logic [3:0] note_pitch,
    output logic       tone_en,
    output logic       note_strobe,
    output logic       busy,
    output logic       done
);

    localparam int PRESC_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BEAT_COUNT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_NOTE  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] presc_r, presc_s;
    logic [3:0]         beat_r, beat_s;     // beats elapsed in the current note
    logic [3:0]         dur_r, dur_s;       // duration of the current note
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic [5:0]         addr_r, addr_s;
    logic [3:0]         pitch_r, pitch_s;
    logic               tone_r, tone_s;
    logic               strobe_r, strobe_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port comes straight from a flop.
    always_comb begin
        state_s  = state_r;
        presc_s  = presc_r;
        beat_s   = beat_r;
        dur_s    = dur_r;
        gap_s    = gap_r;
        addr_s   = addr_r;
        pitch_s  = pitch_r;
        tone_s   = 1'b0;
        strobe_s = 1'b0;

        if (stop) begin
            // Abort: silence and idle; address and pitch are left as they were.
            state_s = ST_IDLE;
            presc_s = {PRESC_W{1'b0}};
            beat_s  = 4'd0;
            gap_s   = {GAP_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_FETCH;
                        addr_s  = 6'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rom_data[3:0] != 4'd0) begin
                        // Note load: counters restart so every note is full length.
                        state_s  = ST_NOTE;
                        pitch_s  = rom_data[7:4];
                        dur_s    = rom_data[3:0];
                        tone_s   = (rom_data[7:4] != 4'd0);
                        strobe_s = 1'b1;
                        presc_s  = {PRESC_W{1'b0}};
                        beat_s   = 4'd0;
                    end else if (loop && (addr_r != 6'd0)) begin
                        state_s = ST_FETCH;
                        addr_s  = 6'd0;
                    end else begin
                        // A marker at address 0 never loops, so an empty tune ends.
                        state_s = ST_DONE;
                    end
                end
                ST_NOTE: begin
                    tone_s = tone_r;
                    if (presc_r == PRESC_LAST) begin
                        presc_s = {PRESC_W{1'b0}};
                        if (beat_r == (dur_r - 4'd1)) begin
                            state_s = ST_GAP;
                            tone_s  = 1'b0;
                            gap_s   = {GAP_W{1'b0}};
                        end else begin
                            beat_s = beat_r + 4'd1;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_r == GAP_LAST) begin
                        state_s = ST_FETCH;
                        addr_s  = addr_r + 6'd1;    // 63 wraps to 0
                        gap_s   = {GAP_W{1'b0}};
                    end else begin
                        gap_s = gap_r + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            presc_r  <= {PRESC_W{1'b0}};
            beat_r   <= 4'd0;
            dur_r    <= 4'd0;
            gap_r    <= {GAP_W{1'b0}};
            addr_r   <= 6'd0;
            pitch_r  <= 4'd0;
            tone_r   <= 1'b0;
            strobe_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            presc_r  <= presc_s;
            beat_r   <= beat_s;
            dur_r    <= dur_s;
            gap_r    <= gap_s;
            addr_r   <= addr_s;
            pitch_r  <= pitch_s;
            tone_r   <= tone_s;
            strobe_r <= strobe_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign rom_addr    = addr_r;
    assign note_pitch  = pitch_r;
    assign tone_en     = tone_r;
    assign note_strobe = strobe_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_tune_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tune_sequencer
// Self-checking bench for tune_sequencer (BEAT_COUNT=4, GAP_CYCLES=2).
// A schedule model expands each fetched tune entry into the list of cycles it
// must produce; the DUT outputs are compared with it on every clock. Directed
// scenarios add hand-computed expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_tune_sequencer;

    localparam int BC = 4;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop;
    logic [7:0] rom_data;
    logic [5:0] rom_addr;
    logic [3:0] note_pitch;
    logic       tone_en, note_strobe, busy, done;

    logic [7:0] tb_rom [64];

    assign rom_data = tb_rom[rom_addr];

    always #5 clk = ~clk;

    tune_sequencer #(.BEAT_COUNT(BC), .GAP_CYCLES(GC)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .loop        (loop),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .note_pitch  (note_pitch),
        .tone_en     (tone_en),
        .note_strobe (note_strobe),
        .busy        (busy),
        .done        (done)
    );

    // One expected output cycle; kind says what the model is doing then.
    typedef struct packed {
        logic [1:0] kind;
        logic [5:0] addr;
        logic [3:0] pitch;
        logic       tone;
        logic       strobe;
        logic       busy;
        logic       done;
    } exp_t;

    localparam logic [1:0] K_IDLE  = 2'd0;
    localparam logic [1:0] K_FETCH = 2'd1;
    localparam logic [1:0] K_PLAY  = 2'd2;
    localparam logic [1:0] K_DONE  = 2'd3;

    exp_t exp_cur = '0;
    exp_t exp_nxt = '0;
    exp_t sched[$];

    int n_tests = 0;
    int n_fail  = 0;

    int         mon_t, cnt_tone, cnt_strobe, cnt_done, first_done, run_len, last_run;
    int         cnt_tone_by_pitch [16];
    bit         saw_wrap;
    logic [5:0] prev_addr;

    function automatic exp_t mk(input logic [1:0] k, input logic [5:0] a, input logic [3:0] p,
                                input logic t, input logic s, input logic b, input logic d);
        mk = {k, a, p, t, s, b, d};
    endfunction

    // Advance the schedule model by one clock given the inputs applied before it.
    task automatic model_step(input logic r, input logic st, input logic sp, input logic lp);
        exp_t       n;
        logic [7:0] ent;
        int         nlen;
        n = exp_cur;
        if (r) begin
            sched.delete();
            n = mk(K_IDLE, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (sp) begin
            sched.delete();
            n = mk(K_IDLE, exp_cur.addr, exp_cur.pitch, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            case (exp_cur.kind)
                K_IDLE: begin
                    if (st) n = mk(K_FETCH, 6'd0, exp_cur.pitch, 1'b0, 1'b0, 1'b1, 1'b0);
                    else    n = mk(K_IDLE, exp_cur.addr, exp_cur.pitch, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                K_FETCH: begin
                    ent = tb_rom[exp_cur.addr];
                    if (ent[3:0] != 4'd0) begin
                        nlen = int'(ent[3:0]) * BC;
                        for (int i = 0; i < nlen; i++)
                            sched.push_back(mk(K_PLAY, exp_cur.addr, ent[7:4], (ent[7:4] != 4'd0),
                                               (i == 0), 1'b1, 1'b0));
                        for (int i = 0; i < GC; i++)
                            sched.push_back(mk(K_PLAY, exp_cur.addr, ent[7:4], 1'b0, 1'b0, 1'b1, 1'b0));
                        sched.push_back(mk(K_FETCH, exp_cur.addr + 6'd1, ent[7:4], 1'b0, 1'b0, 1'b1, 1'b0));
                        n = sched.pop_front();
                    end else if (lp && exp_cur.addr != 6'd0) begin
                        n = mk(K_FETCH, 6'd0, exp_cur.pitch, 1'b0, 1'b0, 1'b1, 1'b0);
                    end else begin
                        n = mk(K_DONE, exp_cur.addr, exp_cur.pitch, 1'b0, 1'b0, 1'b1, 1'b1);
                    end
                end
                K_PLAY: begin
                    n = sched.pop_front();
                end
                default: begin
                    n = mk(K_IDLE, exp_cur.addr, exp_cur.pitch, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            endcase
        end
        exp_nxt = n;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic mon_clear();
        mon_t = 0; cnt_tone = 0; cnt_strobe = 0; cnt_done = 0; first_done = 0;
        run_len = 0; last_run = 0; saw_wrap = 1'b0; prev_addr = rom_addr;
        for (int i = 0; i < 16; i++) cnt_tone_by_pitch[i] = 0;
    endtask

    // Apply inputs for one clock, check the DUT against the model after the edge.
    task automatic tick(input logic r, input logic st, input logic sp, input logic lp);
        rst = r; start = st; stop = sp; loop = lp;
        model_step(r, st, sp, lp);
        @(posedge clk);
        #1;
        exp_cur = exp_nxt;
        check("cycle {addr,pitch,tone,strobe,busy,done}",
              32'({rom_addr, note_pitch, tone_en, note_strobe, busy, done}),
              32'({exp_cur.addr, exp_cur.pitch, exp_cur.tone, exp_cur.strobe, exp_cur.busy, exp_cur.done}));
        mon_t++;
        if (tone_en) begin
            cnt_tone++;
            cnt_tone_by_pitch[note_pitch]++;
            run_len++;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
        if (note_strobe) cnt_strobe++;
        if (done) begin
            cnt_done++;
            if (first_done == 0) first_done = mon_t;
        end
        if (prev_addr == 6'd63 && rom_addr == 6'd0) saw_wrap = 1'b1;
        prev_addr = rom_addr;
    endtask

    task automatic run(input int n, input logic lp);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, lp);
    endtask

    task automatic load_rom(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] fill);
        for (int i = 0; i < 64; i++) tb_rom[i] = fill;
        tb_rom[0] = e0; tb_rom[1] = e1; tb_rom[2] = e2;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        load_rom(8'h32, 8'h13, 8'h00, 8'h00);

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_outputs", 32'({rom_addr, note_pitch, tone_en, note_strobe, busy, done}), 32'd0);
        run(3, 1'b0);

        // Two notes then end marker, loop off
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(39, 1'b0);
        check("basic_pitch3_cycles", 32'(cnt_tone_by_pitch[3]), 32'd8);
        check("basic_pitch1_cycles", 32'(cnt_tone_by_pitch[1]), 32'd12);
        check("basic_done_count", 32'(cnt_done), 32'd1);
        check("basic_done_cycle", 32'(first_done), 32'd28);
        check("basic_strobes", 32'(cnt_strobe), 32'd2);
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Rest note followed by a short note
        load_rom(8'h02, 8'h51, 8'h00, 8'h00);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("rest_strobe_silent", 32'({note_strobe, tone_en}), 32'd2);
        run(28, 1'b0);
        check("rest_tone_cycles", 32'(cnt_tone), 32'd4);
        check("rest_pitch5_cycles", 32'(cnt_tone_by_pitch[5]), 32'd4);
        check("rest_strobes", 32'(cnt_strobe), 32'd2);
        check("rest_done_cycle", 32'(first_done), 32'd20);

        // Looping tune, then stop
        load_rom(8'h32, 8'h13, 8'h00, 8'h00);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        run(59, 1'b1);
        check("loop_no_done", 32'(cnt_done), 32'd0);
        check("loop_strobes", 32'(cnt_strobe), 32'd5);
        check("loop_pitch3_cycles", 32'(cnt_tone_by_pitch[3]), 32'd21);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("loop_stop_busy", 32'({busy, tone_en, done}), 32'd0);
        run(3, 1'b0);

        // Empty tune with loop set must still finish
        load_rom(8'h00, 8'h00, 8'h00, 8'h00);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        run(9, 1'b1);
        check("empty_done_count", 32'(cnt_done), 32'd1);
        check("empty_done_cycle", 32'(first_done), 32'd2);
        check("empty_idle", 32'(busy), 32'd0);

        // Stop and start together during a note
        load_rom(8'h32, 8'h13, 8'h00, 8'h00);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("stopstart_idle", 32'({busy, tone_en}), 32'd0);
        run(5, 1'b0);
        check("stopstart_no_restart", 32'({busy, 8'(cnt_strobe)}), 32'd1);

        // Reset mid-note overrides start/stop; later start plays from 0
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(4, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_mid_note", 32'({rom_addr, note_pitch, tone_en, note_strobe, busy, done}), 32'd0);
        run(5, 1'b0);
        check("rst_no_autoplay", 32'(busy), 32'd0);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(39, 1'b0);
        check("rst_replay_done_cycle", 32'(first_done), 32'd28);
        check("rst_replay_pitch3", 32'(cnt_tone_by_pitch[3]), 32'd8);

        // Full table of longest notes: address wrap and 60-cycle notes
        load_rom(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(64 * 63 + 8, 1'b0);
        check("wrap_long_seen", 32'(saw_wrap), 32'd1);
        check("wrap_long_note_len", 32'(last_run), 32'd60);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Full table of 0xF1 entries: pitch 15, one beat each
        load_rom(8'hF1, 8'hF1, 8'hF1, 8'hF1);
        mon_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        run(64 * 7 + 10, 1'b0);
        check("wrap_short_seen", 32'(saw_wrap), 32'd1);
        check("wrap_short_note_len", 32'(last_run), 32'd4);
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomized tunes and control traffic
        for (int i = 0; i < 64; i++) begin
            tb_rom[i] = {4'($urandom_range(0, 15)),
                         ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15))};
        end
        begin
            logic lp_r;
            lp_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 49) == 0) lp_r = ~lp_r;
                tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 29) == 0),
                     ($urandom_range(0, 249) == 0), lp_r);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
